// File: rtl/icache_assoc_mem.sv
// Set-associative instruction-cache tag/data array with true-LRU replacement,
// multiple combinational lookup ports, an internal-victim fill port and a flush walker.
module icache_assoc_mem #(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 8,
    parameter int IDX_W    = 5,
    parameter int WAYS     = 2,
    parameter int RD_PORTS = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*IDX_W-1:0]    rd_idx,
    input  logic [RD_PORTS*TAG_W-1:0]    rd_tag,
    output logic [RD_PORTS-1:0]          rd_valid,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         flush,
    output logic                         flush_busy
);

    localparam int SETS  = 1 << IDX_W;
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
    typedef enum logic {IDLE, WALK} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              valid_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    ages_t             age_q   [SETS];
    ages_t             age_d   [SETS];
    logic [AGE_W-1:0]  hit_way [RD_PORTS];
    logic [AGE_W-1:0]  victim;
    logic              victim_found;
    logic              fill_go;

    assign flush_busy = (state_q == WALK);
    assign fill_go    = wr_en && !flush_busy;

    // Make 'way' MRU; ways that were more recent than it age by one.
    function automatic ages_t touch(input ages_t a, input logic [AGE_W-1:0] way);
        ages_t r;
        r = a;
        for (int w = 0; w < WAYS; w++) begin
            if (a[w] < a[way]) begin
                r[w] = a[w] + 1'b1;
            end
        end
        r[way] = '0;
        return r;
    endfunction

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            hit_way[p] = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (!flush_busy && valid_q[rd_idx[p*IDX_W +: IDX_W]][w] &&
                    tag_q[rd_idx[p*IDX_W +: IDX_W]][w] == rd_tag[p*TAG_W +: TAG_W]) begin
                    rd_valid[p]                 = 1'b1;
                    hit_way[p]                  = AGE_W'(w);
                    rd_data[p*DATA_W +: DATA_W] = data_q[rd_idx[p*IDX_W +: IDX_W]][w];
                end
            end
        end
    end

    // Port touches apply in port order, then the fill picks its victim from the
    // already-touched ages and touches it last.
    always_comb begin
        age_d = age_q;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rd_en[p] && rd_valid[p]) begin
                age_d[rd_idx[p*IDX_W +: IDX_W]] = touch(age_d[rd_idx[p*IDX_W +: IDX_W]], hit_way[p]);
            end
        end
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
                victim       = AGE_W'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[wr_idx][w]) begin
                victim       = AGE_W'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && age_d[wr_idx][w] == AGE_W'(WAYS-1)) begin
                victim       = AGE_W'(w);
                victim_found = 1'b1;
            end
        end
        if (fill_go) begin
            age_d[wr_idx] = touch(age_d[wr_idx], victim);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = WALK;
                    cnt_d   = '0;
                end
            end
            WALK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(SETS-1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_busy) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[cnt_q][w] <= 1'b0;
                    age_q[cnt_q][w]   <= AGE_W'(w);
                end
            end else begin
                age_q <= age_d;
                if (fill_go) begin
                    valid_q[wr_idx][victim] <= 1'b1;
                end
            end
        end
    end

    // Tag and data need no reset; validity alone decides whether they are used.
    always_ff @(posedge clock) begin
        if (fill_go) begin
            tag_q[wr_idx][victim]  <= wr_tag;
            data_q[wr_idx][victim] <= wr_data;
        end
    end

endmodule

// File: tb/tb_icache_assoc_mem.sv
// Directed bench for icache_assoc_mem: a recency-list model checked every cycle,
// plus hand-computed expectations for the key replacement and flush scenarios.
module tb_icache_assoc_mem;

    localparam int SETS = 32;
    localparam int WAYS = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   rd_en;
    logic [9:0]   rd_idx;
    logic [15:0]  rd_tag;
    logic [1:0]   rd_valid;
    logic [127:0] rd_data;
    logic         wr_en;
    logic [4:0]   wr_idx;
    logic [7:0]   wr_tag;
    logic [63:0]  wr_data;
    logic         flush;
    logic         flush_busy;

    int errors = 0;
    int checks = 0;

    // Model: per set, way contents plus an MRU-first ordering of the ways.
    bit          m_valid [SETS][WAYS];
    logic [7:0]  m_tag   [SETS][WAYS];
    logic [63:0] m_data  [SETS][WAYS];
    int          m_ord   [SETS][WAYS];
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    bit          m_init = 1'b0;

    icache_assoc_mem dut (
        .clock(clock), .reset(reset),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_tag(rd_tag),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
        .flush(flush), .flush_busy(flush_busy)
    );

    initial forever #5 clock = ~clock;

    function automatic void modelLookup(input int p, output bit hit, output logic [63:0] d, output int way);
        int s;
        s   = int'(rd_idx[p*5 +: 5]);
        hit = 1'b0;
        d   = '0;
        way = -1;
        if (m_busy) return;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == rd_tag[p*8 +: 8]) begin
                hit = 1'b1;
                d   = m_data[s][w];
                way = w;
            end
        end
    endfunction

    function automatic void modelTouch(input int s, input int w);
        int k;
        k = 0;
        for (int j = 0; j < WAYS; j++) if (m_ord[s][j] == w) k = j;
        for (int j = k; j > 0; j--) m_ord[s][j] = m_ord[s][j-1];
        m_ord[s][0] = w;
    endfunction

    task automatic modelStep();
        int way [2];
        bit h;
        logic [63:0] d;
        int s, v;
        if (reset) begin
            for (int i = 0; i < SETS; i++)
                for (int w = 0; w < WAYS; w++) begin
                    m_valid[i][w] = 1'b0;
                    m_ord[i][w]   = w;
                end
            m_busy = 1'b0;
            m_cnt  = 0;
            m_init = 1'b1;
            return;
        end
        if (!m_init) return;
        if (m_busy) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[m_cnt][w] = 1'b0;
                m_ord[m_cnt][w]   = w;
            end
            if (m_cnt == SETS-1) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
            return;
        end
        for (int p = 0; p < 2; p++) modelLookup(p, h, d, way[p]);
        for (int p = 0; p < 2; p++)
            if (rd_en[p] && way[p] >= 0) modelTouch(int'(rd_idx[p*5 +: 5]), way[p]);
        if (wr_en) begin
            s = int'(wr_idx);
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && m_valid[s][w] && m_tag[s][w] == wr_tag) v = w;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_valid[s][w]) v = w;
            if (v < 0) v = m_ord[s][WAYS-1];
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = wr_tag;
            m_data[s][v]  = wr_data;
            modelTouch(s, v);
        end
        if (flush) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    endtask

    initial forever begin
        @(posedge clock);
        modelStep();
    end

    // Every cycle, mid-way between edges, compare outputs with the model.
    initial forever begin
        bit h;
        logic [63:0] d;
        int w;
        @(negedge clock);
        #3;
        if (m_init) begin
            checks++;
            if (flush_busy !== m_busy) begin
                errors++;
                $display("[TB] FAIL model_busy t=%0t got %b expected %b", $time, flush_busy, m_busy);
            end
            for (int p = 0; p < 2; p++) begin
                modelLookup(p, h, d, w);
                checks++;
                if (rd_valid[p] !== h || rd_data[p*64 +: 64] !== d) begin
                    errors++;
                    $display("[TB] FAIL model_port%0d t=%0t got valid=%b data=%h expected valid=%b data=%h",
                             p, $time, rd_valid[p], rd_data[p*64 +: 64], h, d);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic [1:0] ren,
                                 input logic [4:0] i0, input logic [7:0] t0,
                                 input logic [4:0] i1, input logic [7:0] t1,
                                 input logic we, input logic [4:0] wi, input logic [7:0] wt,
                                 input logic [63:0] wd, input logic fl);
        @(negedge clock);
        reset   = rst;
        rd_en   = ren;
        rd_idx  = {i1, i0};
        rd_tag  = {t1, t0};
        wr_en   = we;
        wr_idx  = wi;
        wr_tag  = wt;
        wr_data = wd;
        flush   = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 64'h0, 1'b0);
    endtask

    task automatic fill(input logic [4:0] i, input logic [7:0] t, input logic [63:0] d);
        applyStimulus(1'b0, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, i, t, d, 1'b0);
    endtask

    task automatic look(input logic [1:0] ren, input logic [4:0] i0, input logic [7:0] t0,
                        input logic [4:0] i1, input logic [7:0] t1);
        applyStimulus(1'b0, ren, i0, t0, i1, t1, 1'b0, 5'd0, 8'h00, 64'h0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] ev,
                               input logic [63:0] ed0, input logic [63:0] ed1);
        #3;
        checks++;
        if (rd_valid !== ev || rd_data[63:0] !== ed0 || rd_data[127:64] !== ed1) begin
            errors++;
            $display("[TB] FAIL %s got valid=%b data1=%h data0=%h expected valid=%b data1=%h data0=%h",
                     name, rd_valid, rd_data[127:64], rd_data[63:0], ev, ed1, ed0);
        end
    endtask

    task automatic checkBusy(input string name, input logic eb);
        checks++;
        if (flush_busy !== eb) begin
            errors++;
            $display("[TB] FAIL %s got flush_busy=%b expected %b", name, flush_busy, eb);
        end
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b1; rd_en = '0; rd_idx = '0; rd_tag = '0;
        wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0; flush = 1'b0;

        applyStimulus(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 64'h0, 1'b0);
        applyStimulus(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 64'h0, 1'b0);
        look(2'b00, 5'd3, 8'h00, 5'd3, 8'h00);
        checkOutput("reset_zero_tag", 2'b00, 64'h0, 64'h0);
        checkBusy("reset_busy", 1'b0);

        // Two fills, then a third evicts the oldest (A1).
        fill(5'd5, 8'hA1, 64'h1111);
        fill(5'd5, 8'hB2, 64'h2222);
        look(2'b00, 5'd5, 8'hA1, 5'd5, 8'hB2);
        checkOutput("two_fills_hit", 2'b11, 64'h1111, 64'h2222);
        fill(5'd5, 8'hC3, 64'h4444);
        look(2'b00, 5'd5, 8'hA1, 5'd5, 8'hC3);
        checkOutput("lru_evict_a1", 2'b10, 64'h0, 64'h4444);
        look(2'b00, 5'd5, 8'hB2, 5'd5, 8'hC3);
        checkOutput("lru_keep_b2", 2'b11, 64'h2222, 64'h4444);

        // A qualified hit on A1 makes B2 the victim instead.
        fill(5'd6, 8'hA1, 64'h1111);
        fill(5'd6, 8'hB2, 64'h2222);
        look(2'b01, 5'd6, 8'hA1, 5'd6, 8'hB2);
        checkOutput("touch_hit", 2'b11, 64'h1111, 64'h2222);
        fill(5'd6, 8'hC3, 64'h4444);
        look(2'b00, 5'd6, 8'hA1, 5'd6, 8'hB2);
        checkOutput("touch_evict_b2", 2'b01, 64'h1111, 64'h0);
        look(2'b00, 5'd6, 8'hC3, 5'd6, 8'hA1);
        checkOutput("touch_keep_a1", 2'b11, 64'h4444, 64'h1111);

        // Re-fill of an existing tag overwrites in place and becomes MRU.
        fill(5'd5, 8'hB2, 64'h3333);
        look(2'b00, 5'd5, 8'hB2, 5'd5, 8'hC3);
        checkOutput("refill_same_way", 2'b11, 64'h3333, 64'h4444);
        fill(5'd5, 8'hD4, 64'h5555);
        look(2'b00, 5'd5, 8'hC3, 5'd5, 8'hD4);
        checkOutput("refill_then_evict_c3", 2'b10, 64'h0, 64'h5555);
        look(2'b00, 5'd5, 8'hB2, 5'd5, 8'hD4);
        checkOutput("refill_keep_b2", 2'b11, 64'h3333, 64'h5555);

        // Both ports touch different ways: port 1's way ends MRU.
        fill(5'd7, 8'hA1, 64'h1111);
        fill(5'd7, 8'hB2, 64'h2222);
        look(2'b11, 5'd7, 8'hB2, 5'd7, 8'hA1);
        checkOutput("dual_touch", 2'b11, 64'h2222, 64'h1111);
        fill(5'd7, 8'hC3, 64'h4444);
        look(2'b00, 5'd7, 8'hB2, 5'd7, 8'hC3);
        checkOutput("dual_touch_evict_b2", 2'b10, 64'h0, 64'h4444);

        // Same-cycle fill never hits its own tag.
        applyStimulus(1'b0, 2'b00, 5'd8, 8'h99, 5'd8, 8'h99, 1'b1, 5'd8, 8'h99, 64'h9999, 1'b0);
        checkOutput("read_during_write", 2'b00, 64'h0, 64'h0);
        look(2'b00, 5'd8, 8'h99, 5'd8, 8'h99);
        checkOutput("fill_next_cycle", 2'b11, 64'h9999, 64'h9999);

        // Flush walk with a same-cycle fill and a dropped mid-walk fill.
        fill(5'd10, 8'h10, 64'hA0);
        fill(5'd11, 8'h11, 64'hA1);
        fill(5'd12, 8'h12, 64'hA2);
        fill(5'd13, 8'h13, 64'hA3);
        look(2'b00, 5'd10, 8'h10, 5'd13, 8'h13);
        checkOutput("pre_flush_hit", 2'b11, 64'hA0, 64'hA3);
        applyStimulus(1'b0, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b1, 5'd9, 8'h55, 64'h5A5A, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) fill(5'd20, 8'hEE, 64'hEEEE);
            else idle();
            #3;
            if (flush_busy === 1'b1) busy_cnt++;
            else if (busy_cnt > 0) break;
        end
        checks++;
        if (busy_cnt != 32) begin
            errors++;
            $display("[TB] FAIL flush_busy_len got %0d cycles expected 32", busy_cnt);
        end
        look(2'b00, 5'd10, 8'h10, 5'd13, 8'h13);
        checkOutput("post_flush_miss", 2'b00, 64'h0, 64'h0);
        look(2'b00, 5'd9, 8'h55, 5'd20, 8'hEE);
        checkOutput("post_flush_dropped", 2'b00, 64'h0, 64'h0);
        look(2'b00, 5'd5, 8'hB2, 5'd6, 8'hA1);
        checkOutput("post_flush_old", 2'b00, 64'h0, 64'h0);

        // Reset on cycle 10 of a flush aborts the walk.
        fill(5'd0, 8'h11, 64'hAAAA);
        applyStimulus(1'b0, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 64'h0, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        applyStimulus(1'b1, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 64'h0, 1'b0);
        look(2'b00, 5'd0, 8'h11, 5'd8, 8'h99);
        checkOutput("reset_abort_miss", 2'b00, 64'h0, 64'h0);
        checkBusy("reset_abort_busy", 1'b0);
        fill(5'd0, 8'h77, 64'h8888);
        look(2'b00, 5'd0, 8'h77, 5'd0, 8'h77);
        checkOutput("fill_after_abort", 2'b11, 64'h8888, 64'h8888);

        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
